// File: rtl/pool_window_gen.sv
// pool_window_gen
//   Feeder for the 2x2 pooling stage. Takes a raster-order pixel stream,
//   stores the even (top) row of each row pair in a line buffer, and emits
//   non-overlapping 2x2 windows (stride 2) as four parallel words through a
//   one-deep output register with a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_width, cfg_height frame geometry, latched on the first pixel of a frame
//   pix_in/valid/ready    input pixel stream
//   win_0..win_3          window words: top-left, top-right, bottom-left, bottom-right
//   win_valid/ready       output window handshake
//   frame_done            1-cycle pulse after the last pixel of a frame is accepted
//   cfg_err               sticky flag: current/last frame started with illegal cfg
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | waiting for first pixel of a frame; latches cfg on acceptance
// S_TOP     | even row: pixels written into the line buffer
// S_BOT     | odd row: pairs of pixels combined with line buffer into windows
// S_DISCARD | illegal cfg: pixels are counted and swallowed, no windows

module pool_window_gen #(
    parameter int DATA_W = 16,
    parameter int MAX_W  = 64,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam int AW = $clog2(MAX_W);
    localparam logic [DIM_W:0] MAX_W_L = (DIM_W+1)'(MAX_W);

    typedef enum logic [1:0] {S_IDLE, S_TOP, S_BOT, S_DISCARD} state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic              init_q;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] win0_q, win0_d, win1_q, win1_d, win2_q, win2_d, win3_q, win3_d;
    logic              win_valid_q, win_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              cfg_err_q, cfg_err_d;

    logic [DATA_W-1:0] linebuf_q [MAX_W];

    logic              pix_acc;
    logic              in_idle;
    logic [DIM_W-1:0]  cur_w, cur_h;
    logic              cfg_legal;
    logic              col_last, row_last, frame_end;
    logic              top_wr, bot_acc, win_load;
    logic [AW-1:0]     lb_idx, lb_idx_even;

    // init_q keeps pix_ready low for the first cycle after reset release.
    assign pix_ready = init_q && (!win_valid_q || win_ready);
    assign pix_acc   = pix_valid && pix_ready;
    assign in_idle   = (state_q == S_IDLE);

    // In IDLE the accepted pixel is the first of the frame, so geometry comes
    // straight from the cfg inputs rather than the (stale) latched copies.
    assign cur_w     = in_idle ? cfg_width  : width_q;
    assign cur_h     = in_idle ? cfg_height : height_q;
    assign cfg_legal = (cfg_width >= DIM_W'(2)) && ({1'b0, cfg_width} <= MAX_W_L)
                       && (cfg_height >= DIM_W'(2));

    assign col_last  = (col_q == cur_w - DIM_W'(1));
    assign row_last  = (row_q == cur_h - DIM_W'(1));
    assign frame_end = (cur_w == '0) || (cur_h == '0) || (col_last && row_last);

    assign lb_idx      = col_q[AW-1:0];
    assign lb_idx_even = {lb_idx[AW-1:1], 1'b0};

    assign top_wr   = pix_acc && ((in_idle && cfg_legal) || (state_q == S_TOP));
    assign bot_acc  = pix_acc && (state_q == S_BOT);
    assign win_load = bot_acc && col_q[0];

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        width_d      = width_q;
        height_d     = height_q;
        cfg_err_d    = cfg_err_q;
        frame_done_d = 1'b0;

        if (pix_acc) begin
            if (in_idle) begin
                width_d   = cfg_width;
                height_d  = cfg_height;
                cfg_err_d = !cfg_legal;
            end
            if (frame_end) begin
                state_d      = S_IDLE;
                col_d        = '0;
                row_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                if (in_idle) begin
                    state_d = cfg_legal ? S_TOP : S_DISCARD;
                end
                if (col_last) begin
                    col_d = '0;
                    row_d = row_q + DIM_W'(1);
                    if (state_d != S_DISCARD) begin
                        // next row is odd when the current one is even
                        state_d = row_q[0] ? S_TOP : S_BOT;
                    end
                end else begin
                    col_d = col_q + DIM_W'(1);
                end
            end
        end
    end

    always_comb begin
        left_d      = left_q;
        win0_d      = win0_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        win3_d      = win3_q;
        win_valid_d = win_valid_q;

        if (bot_acc && !col_q[0]) begin
            left_d = pix_in;
        end

        if (win_load) begin
            win0_d      = linebuf_q[lb_idx_even];
            win1_d      = linebuf_q[lb_idx];
            win2_d      = left_q;
            win3_d      = pix_in;
            win_valid_d = 1'b1;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            init_q       <= 1'b0;
            left_q       <= '0;
            win0_q       <= '0;
            win1_q       <= '0;
            win2_q       <= '0;
            win3_q       <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            width_q      <= width_d;
            height_q     <= height_d;
            init_q       <= 1'b1;
            left_q       <= left_d;
            win0_q       <= win0_d;
            win1_q       <= win1_d;
            win2_q       <= win2_d;
            win3_q       <= win3_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Line buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (top_wr) begin
            linebuf_q[lb_idx] <= pix_in;
        end
    end

    assign win_0      = win0_q;
    assign win_1      = win1_q;
    assign win_2      = win2_q;
    assign win_3      = win3_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pool_window_gen.sv
module tb_pool_window_gen;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_height;
    logic [15:0] pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] win_0, win_1, win_2, win_3;
    logic        win_valid;
    logic        win_ready;
    logic        frame_done;
    logic        cfg_err;

    int total  = 0;
    int passed = 0;
    int fd_cnt = 0;
    int stall_sum = 0;
    logic [63:0] wq[$];

    pool_window_gen #(.DATA_W(16), .MAX_W(64), .DIM_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_0      (win_0),
        .win_1      (win_1),
        .win_2      (win_2),
        .win_3      (win_3),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+2, so at negedge they are stable; a window
    // seen valid&&ready here transfers at the following posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid && win_ready) wq.push_back({win_0, win_1, win_2, win_3});
            if (frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_pix(input logic [15:0] v);
        int n;
        pix_in    = v;
        pix_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (pix_ready) break;
            n++;
            stall_sum++;
            if (n > 100) begin
                total++;
                $error("FAIL send_timeout: pixel %h observed no pix_ready expected accept", v);
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int cycles);
        pix_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_win(input string tag, input logic [15:0] a, b, c, d);
        if (wq.size() == 0) chk(tag, 64'hdead, {a, b, c, d});
        else chk(tag, wq.pop_front(), {a, b, c, d});
    endtask

    task automatic start_test(input logic [7:0] w, input logic [7:0] h);
        wq.delete();
        fd_cnt     = 0;
        cfg_width  = w;
        cfg_height = h;
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_width  = 8'd0;
        cfg_height = 8'd0;
        pix_in     = 16'd0;
        pix_valid  = 1'b0;
        win_ready  = 1'b1;

        // reset values
        #12;
        chk("rst_win_valid", 64'(win_valid), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_win", {win_0, win_1, win_2, win_3}, 64'd0);
        chk("rst_pix_ready", 64'(pix_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_pix_ready_low", 64'(pix_ready), 64'd0);
        @(posedge clk);
        #2;
        chk("rel_pix_ready_high", 64'(pix_ready), 64'd1);

        // T1: 4x2, win_ready=1
        start_test(8'd4, 8'd2);
        for (int i = 1; i <= 6; i++) send_pix(16'(i));
        chk("t1_win1_valid", 64'(win_valid), 64'd1);
        chk("t1_win1_data", {win_0, win_1, win_2, win_3}, {16'd1, 16'd2, 16'd5, 16'd6});
        send_pix(16'd7);
        send_pix(16'd8);
        chk("t1_frame_done", 64'(frame_done), 64'd1);
        chk("t1_win2_data", {win_0, win_1, win_2, win_3}, {16'd3, 16'd4, 16'd7, 16'd8});
        idle(1);
        chk("t1_frame_done_pulse", 64'(frame_done), 64'd0);
        idle(2);
        chk("t1_win_count", 64'(wq.size()), 64'd2);
        check_win("t1_w0", 16'd1, 16'd2, 16'd5, 16'd6);
        check_win("t1_w1", 16'd3, 16'd4, 16'd7, 16'd8);
        chk("t1_fd_count", 64'(fd_cnt), 64'd1);

        // T2: same frame with downstream stalled after the first window
        start_test(8'd4, 8'd2);
        win_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send_pix(16'(i));
        pix_in    = 16'd7;
        pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stall_pix_ready", 64'(pix_ready), 64'd0);
            chk("t2_stall_hold", {win_valid, win_0, win_1, win_2, win_3},
                {1'b1, 16'd1, 16'd2, 16'd5, 16'd6});
        end
        @(posedge clk);
        #2;
        win_ready = 1'b1;
        send_pix(16'd7);
        send_pix(16'd8);
        idle(3);
        chk("t2_win_count", 64'(wq.size()), 64'd2);
        check_win("t2_w0", 16'd1, 16'd2, 16'd5, 16'd6);
        check_win("t2_w1", 16'd3, 16'd4, 16'd7, 16'd8);
        chk("t2_fd_count", 64'(fd_cnt), 64'd1);

        // T3: 5x3, odd width and height; cfg change mid-frame ignored
        start_test(8'd5, 8'd3);
        send_pix(16'd1);
        cfg_width  = 8'd2;
        cfg_height = 8'd2;
        for (int i = 2; i <= 14; i++) begin
            send_pix(16'(i));
            chk("t3_no_early_done", 64'(frame_done), 64'd0);
        end
        send_pix(16'd15);
        chk("t3_frame_done", 64'(frame_done), 64'd1);
        idle(3);
        chk("t3_win_count", 64'(wq.size()), 64'd2);
        check_win("t3_w0", 16'd1, 16'd2, 16'd6, 16'd7);
        check_win("t3_w1", 16'd3, 16'd4, 16'd8, 16'd9);
        chk("t3_fd_count", 64'(fd_cnt), 64'd1);

        // T4: cfg_width=1 is illegal, then a legal 2x2 frame clears cfg_err
        start_test(8'd1, 8'd2);
        send_pix(16'h0aa1);
        chk("t4_cfg_err_set", 64'(cfg_err), 64'd1);
        chk("t4_no_done_first", 64'(frame_done), 64'd0);
        send_pix(16'h0aa2);
        chk("t4_frame_done", 64'(frame_done), 64'd1);
        idle(2);
        chk("t4_cfg_err_sticky", 64'(cfg_err), 64'd1);
        chk("t4_no_windows", 64'(wq.size()), 64'd0);
        chk("t4_fd_count", 64'(fd_cnt), 64'd1);
        start_test(8'd2, 8'd2);
        send_pix(16'd21);
        chk("t4_cfg_err_clear", 64'(cfg_err), 64'd0);
        send_pix(16'd22);
        send_pix(16'd23);
        send_pix(16'd24);
        idle(3);
        chk("t4_legal_win_count", 64'(wq.size()), 64'd1);
        check_win("t4_legal_w0", 16'd21, 16'd22, 16'd23, 16'd24);

        // T5: reset mid-frame, then a fresh 2x2 frame
        start_test(8'd4, 8'd2);
        send_pix(16'd1);
        send_pix(16'd2);
        send_pix(16'd3);
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outputs", {win_valid, frame_done, cfg_err, pix_ready}, 64'd0);
        chk("t5_rst_win", {win_0, win_1, win_2, win_3}, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("t5_rel_pix_ready_low", 64'(pix_ready), 64'd0);
        start_test(8'd2, 8'd2);
        send_pix(16'd9);
        send_pix(16'd10);
        send_pix(16'd11);
        send_pix(16'd12);
        idle(3);
        chk("t5_win_count", 64'(wq.size()), 64'd1);
        check_win("t5_w0", 16'd9, 16'd10, 16'd11, 16'd12);
        chk("t5_fd_count", 64'(fd_cnt), 64'd1);

        // T6: back-to-back 2x2 frames with continuous pix_valid
        start_test(8'd2, 8'd2);
        stall_sum = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) send_pix(16'(16'h100 * (f + 1) + i));
        end
        idle(3);
        chk("t6_no_stall", 64'(stall_sum), 64'd0);
        chk("t6_win_count", 64'(wq.size()), 64'd3);
        check_win("t6_w0", 16'h100, 16'h101, 16'h102, 16'h103);
        check_win("t6_w1", 16'h200, 16'h201, 16'h202, 16'h203);
        check_win("t6_w2", 16'h300, 16'h301, 16'h302, 16'h303);
        chk("t6_fd_count", 64'(fd_cnt), 64'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
